mem_stage_ctrl: RTL and testbench

MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

---
 rtl/mem_stage_pkg.sv | 20 ++
 rtl/mem_bus_timer.sv | 40 ++++
 rtl/mem_stage_ctrl.sv | 148 ++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM-stage data-bus controller.
package mem_stage_pkg;

    // Controller states: wait for an access, bus handshake, one-cycle result slot.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } mem_state_e;

    // Value written to mem_rdata when a load gives up waiting for the bus.
    localparam logic [31:0] TIMEOUT_FILL = 32'hDEAD_BEEF;

    // Width of the ack-wait counter; covers TIMEOUT_CYCLES up to 65535.
    localparam int TIMER_W = 16;

    // Bus addresses are word aligned.
    localparam logic [31:0] ADDR_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/mem_bus_timer.sv
// Ack-wait counter for the MEM-stage bus controller. Counts enabled cycles
// and flags the cycle in which the LIMIT-th consecutive enabled cycle occurs.
import mem_stage_pkg::*;

module mem_bus_timer #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TIMER_W-1:0] count_q;
    logic [TIMER_W-1:0] count_d;

    // Next count: clear wins, otherwise advance while enabled.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // The first enabled cycle sees count 0, so LIMIT-1 marks the LIMIT-th.
    assign expired = enable && (count_q == TIMER_W'(LIMIT - 1));

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage data-bus controller: turns load/store instructions into a
// req/ack bus handshake and stalls the pipeline until the access finishes.
// Optional ack timeout enabled by defining MEM_BUS_TIMEOUT_EN.
import mem_stage_pkg::*;

module mem_stage_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        mem_flush,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_stall,
    output logic [31:0] mem_rdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        bus_timeout
);

    mem_state_e  state_q, state_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic        flush_q, flush_d;
    logic        access;
    logic        flushed;

    // A store wins when read and write are both set, so only mem_write matters for bus_we.
    assign access  = mem_valid && (mem_read || mem_write) && !mem_flush;
    // A flush seen at any point of the handshake discards the result.
    assign flushed = flush_q || mem_flush;

`ifdef MEM_BUS_TIMEOUT_EN
    logic timer_expired;
    logic bus_timeout_q, bus_timeout_d;

    mem_bus_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_q != S_REQ),
        .enable  (state_q == S_REQ),
        .expired (timer_expired)
    );

    // Timeout pulse is asserted for the cycle after the giving-up edge.
    always_comb begin
        bus_timeout_d = (state_q == S_REQ) && !bus_ack && timer_expired;
    end

    // Timeout pulse register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_timeout_q <= 1'b0;
        end else begin
            bus_timeout_q <= bus_timeout_d;
        end
    end

    assign bus_timeout = bus_timeout_q;
`else
    assign bus_timeout = 1'b0;
`endif

    // Next-state and datapath capture for the bus handshake.
    always_comb begin
        state_d     = state_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        mem_rdata_d = mem_rdata_q;
        flush_d     = flush_q;
        case (state_q)
            S_IDLE: begin
                if (access) begin
                    state_d     = S_REQ;
                    bus_we_d    = mem_write;
                    bus_addr_d  = mem_addr & ADDR_MASK;
                    bus_wdata_d = mem_wdata;
                    flush_d     = 1'b0;
                end
            end
            S_REQ: begin
                flush_d = flushed;
                if (bus_ack) begin
                    state_d = flushed ? S_IDLE : S_DONE;
                    flush_d = 1'b0;
                    if (!bus_we_q && !flushed) begin
                        mem_rdata_d = bus_rdata;
                    end
                end
`ifdef MEM_BUS_TIMEOUT_EN
                else if (timer_expired) begin
                    state_d = flushed ? S_IDLE : S_DONE;
                    flush_d = 1'b0;
                    if (!bus_we_q && !flushed) begin
                        mem_rdata_d = TIMEOUT_FILL;
                    end
                end
`endif
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Controller state and registered bus outputs; reset takes effect immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            mem_rdata_q <= '0;
            flush_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            mem_rdata_q <= mem_rdata_d;
            flush_q     <= flush_d;
        end
    end

    // Stall is combinational so the pipeline freezes in the cycle the access is seen.
    assign mem_stall = !reset && (((state_q == S_IDLE) && access) || (state_q == S_REQ));
    assign bus_req   = (state_q == S_REQ);
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign mem_rdata = mem_rdata_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl; define MEM_BUS_TIMEOUT_EN for the timeout scenario.
`timescale 1ns/1ps
module tb_mem_stage_ctrl;

    localparam int TB_TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_valid, mem_read, mem_write, mem_flush;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_stall;
    logic [31:0] mem_rdata;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        bus_timeout;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] model_rdata = 32'h0;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          stalls;
        logic        restall;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          stalls;
        int          reqs;
        logic        unstable;
        logic        timeout;
        logic        restall;
        logic        finished;
    } obs_t;

    exp_t sbq[$];

    localparam logic [31:0] LS_ADDR [4] = '{32'h0000_1006, 32'h0000_0020, 32'h0000_0103, 32'hFFFF_FFFF};
    localparam logic [31:0] LS_WD   [4] = '{32'h0000_0000, 32'hCAFE_0001, 32'hA5A5_0003, 32'h0BAD_F00D};
    localparam logic [31:0] LS_RD   [4] = '{32'h1234_5678, 32'h5555_5555, 32'h0000_6666, 32'h8765_4321};
    localparam logic        LS_R    [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    localparam logic        LS_W    [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    localparam int          LS_ACK  [4] = '{1, 0, 2, 0};

    mem_stage_ctrl #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_valid   (mem_valid),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_flush   (mem_flush),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_stall   (mem_stall),
        .mem_rdata   (mem_rdata),
        .bus_req     (bus_req),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_ack     (bus_ack),
        .bus_rdata   (bus_rdata),
        .bus_timeout (bus_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // Drives one instruction and records what the DUT did; ack_at/flush_at are REQ-cycle indices, -1 = never.
    task automatic run_access(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input int ack_at,
                              input logic [31:0] rdata, input int flush_at, output obs_t o);
        o.addr = '0; o.we = 1'b0; o.wdata = '0; o.rdata = '0; o.stalls = 0; o.reqs = 0;
        o.unstable = 1'b0; o.timeout = 1'b0; o.restall = 1'b0; o.finished = 1'b0;
        @(negedge clk);
        mem_valid = 1'b1; mem_read = rd; mem_write = wr; mem_addr = addr;
        mem_wdata = wdata; mem_flush = 1'b0; bus_rdata = rdata;
        for (int cyc = 0; cyc < 64 && !o.finished; cyc++) begin
            #1;
            if (mem_stall) o.stalls++;
            if (bus_req) begin
                if (o.reqs == 0) begin
                    o.addr = bus_addr; o.we = bus_we; o.wdata = bus_wdata;
                end else if (bus_addr !== o.addr || bus_we !== o.we || bus_wdata !== o.wdata) begin
                    o.unstable = 1'b1;
                end
                if (o.reqs == flush_at) mem_flush = 1'b1;
                bus_ack = (o.reqs == ack_at);
                o.reqs++;
            end else begin
                bus_ack = 1'b0;
                if (!mem_stall && o.reqs > 0) begin
                    o.finished = 1'b1;
                    o.rdata    = mem_rdata;
                    o.timeout  = bus_timeout;
                    mem_flush  = 1'b0;
                    #1 o.restall = mem_stall;
                    mem_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
                    #1;
                end
            end
            if (!o.finished) @(negedge clk);
        end
        bus_ack = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_checks++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL rst_bus_req got %b exp 0", bus_req); end
        n_checks++; if (bus_we !== 1'b0) begin n_fail++; $display("FAIL rst_bus_we got %b exp 0", bus_we); end
        n_checks++; if (bus_addr !== 32'h0) begin n_fail++; $display("FAIL rst_bus_addr got %h exp 0", bus_addr); end
        n_checks++; if (bus_wdata !== 32'h0) begin n_fail++; $display("FAIL rst_bus_wdata got %h exp 0", bus_wdata); end
        n_checks++; if (mem_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_mem_rdata got %h exp 0", mem_rdata); end
        n_checks++; if (bus_timeout !== 1'b0) begin n_fail++; $display("FAIL rst_bus_timeout got %b exp 0", bus_timeout); end
        n_checks++; if (mem_stall !== 1'b0) begin n_fail++; $display("FAIL rst_mem_stall got %b exp 0", mem_stall); end
    endtask

    task automatic test_passthrough();
        logic pv [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic pr [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic pw [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic pf [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mem_valid = pv[i]; mem_read = pr[i]; mem_write = pw[i]; mem_flush = pf[i];
            mem_addr = 32'h0000_0800 + 32'(i);
            for (int c = 0; c < 2; c++) begin
                #1;
                n_checks++; if (mem_stall !== 1'b0) begin n_fail++; $display("FAIL pass%0d_stall got %b exp 0", i, mem_stall); end
                n_checks++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL pass%0d_bus_req got %b exp 0", i, bus_req); end
                @(negedge clk);
            end
        end
        mem_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_flush = 1'b0;
    endtask

    task automatic test_load_store();
        exp_t e;
        obs_t o;
        for (int i = 0; i < 4; i++) begin
            e.addr = LS_ADDR[i] & 32'hFFFF_FFFC;
            e.we = LS_W[i];
            e.wdata = LS_WD[i];
            e.stalls = 2 + LS_ACK[i];
            e.rdata = LS_W[i] ? model_rdata : LS_RD[i];
            e.restall = 1'b0;
            model_rdata = e.rdata;
            sbq.push_back(e);
            run_access(LS_R[i], LS_W[i], LS_ADDR[i], LS_WD[i], LS_ACK[i], LS_RD[i], -1, o);
            e = sbq.pop_front();
            n_checks++; if (o.finished !== 1'b1) begin n_fail++; $display("FAIL ls%0d_done got %b exp 1", i, o.finished); end
            n_checks++; if (o.addr !== e.addr) begin n_fail++; $display("FAIL ls%0d_bus_addr got %h exp %h", i, o.addr, e.addr); end
            n_checks++; if (o.we !== e.we) begin n_fail++; $display("FAIL ls%0d_bus_we got %b exp %b", i, o.we, e.we); end
            n_checks++; if (o.wdata !== e.wdata) begin n_fail++; $display("FAIL ls%0d_bus_wdata got %h exp %h", i, o.wdata, e.wdata); end
            n_checks++; if (o.stalls != e.stalls) begin n_fail++; $display("FAIL ls%0d_stalls got %0d exp %0d", i, o.stalls, e.stalls); end
            n_checks++; if (o.rdata !== e.rdata) begin n_fail++; $display("FAIL ls%0d_mem_rdata got %h exp %h", i, o.rdata, e.rdata); end
            n_checks++; if (o.unstable !== 1'b0) begin n_fail++; $display("FAIL ls%0d_bus_stable got %b exp 0", i, o.unstable); end
            n_checks++; if (o.restall !== e.restall) begin n_fail++; $display("FAIL ls%0d_done_ignores_access got %b exp %b", i, o.restall, e.restall); end
            n_checks++; if (o.timeout !== 1'b0) begin n_fail++; $display("FAIL ls%0d_timeout got %b exp 0", i, o.timeout); end
        end
    endtask

    task automatic test_flush();
        exp_t e;
        obs_t o;
        e.addr = 32'h0000_0300; e.we = 1'b0; e.wdata = 32'h0; e.stalls = 5;
        e.rdata = model_rdata; e.restall = 1'b1;
        sbq.push_back(e);
        run_access(1'b1, 1'b0, 32'h0000_0300, 32'h0, 3, 32'hFFFF_FFFF, 0, o);
        e = sbq.pop_front();
        n_checks++; if (o.reqs != 4) begin n_fail++; $display("FAIL flush_req_cycles got %0d exp 4", o.reqs); end
        n_checks++; if (o.stalls != e.stalls) begin n_fail++; $display("FAIL flush_stalls got %0d exp %0d", o.stalls, e.stalls); end
        n_checks++; if (o.rdata !== e.rdata) begin n_fail++; $display("FAIL flush_mem_rdata got %h exp %h", o.rdata, e.rdata); end
        n_checks++; if (o.restall !== e.restall) begin n_fail++; $display("FAIL flush_no_done got %b exp %b", o.restall, e.restall); end
        n_checks++; if (o.addr !== e.addr) begin n_fail++; $display("FAIL flush_bus_addr got %h exp %h", o.addr, e.addr); end
    endtask

    task automatic test_back_to_back();
        obs_t o;
        run_access(1'b1, 1'b0, 32'h0000_0500, 32'h0, 1, 32'h1111_2222, -1, o);
        model_rdata = 32'h1111_2222;
        n_checks++; if (o.rdata !== model_rdata) begin n_fail++; $display("FAIL b2b_first_rdata got %h exp %h", o.rdata, model_rdata); end
        bus_rdata = 32'hBAD0_BAD0;
        bus_ack = 1'b1;
        @(negedge clk); #1;
        n_checks++; if (mem_rdata !== model_rdata) begin n_fail++; $display("FAIL b2b_stray_ack_rdata got %h exp %h", mem_rdata, model_rdata); end
        n_checks++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL b2b_stray_ack_req got %b exp 0", bus_req); end
        bus_ack = 1'b0;
        run_access(1'b1, 1'b0, 32'h0000_0504, 32'h0, 0, 32'h3333_4444, -1, o);
        model_rdata = 32'h3333_4444;
        n_checks++; if (o.addr !== 32'h0000_0504) begin n_fail++; $display("FAIL b2b_second_addr got %h exp 00000504", o.addr); end
        n_checks++; if (o.stalls != 2) begin n_fail++; $display("FAIL b2b_second_stalls got %0d exp 2", o.stalls); end
        n_checks++; if (o.rdata !== model_rdata) begin n_fail++; $display("FAIL b2b_second_rdata got %h exp %h", o.rdata, model_rdata); end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        @(negedge clk);
        mem_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; mem_addr = 32'h0000_0044;
        @(negedge clk); #1;
        n_checks++; if (bus_req !== 1'b1) begin n_fail++; $display("FAIL rmid_in_req got %b exp 1", bus_req); end
        #2 reset = 1'b1;
        #1;
        n_checks++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL rmid_bus_req got %b exp 0", bus_req); end
        n_checks++; if (mem_stall !== 1'b0) begin n_fail++; $display("FAIL rmid_mem_stall got %b exp 0", mem_stall); end
        n_checks++; if (mem_rdata !== 32'h0) begin n_fail++; $display("FAIL rmid_mem_rdata got %h exp 0", mem_rdata); end
        n_checks++; if (bus_addr !== 32'h0) begin n_fail++; $display("FAIL rmid_bus_addr got %h exp 0", bus_addr); end
        model_rdata = 32'h0;
        mem_valid = 1'b0; mem_read = 1'b0;
        @(negedge clk); reset = 1'b0;
        @(negedge clk); #1;
        n_checks++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL rmid_no_residual got %b exp 0", bus_req); end
        run_access(1'b1, 1'b0, 32'h0000_0048, 32'h0, 1, 32'h7777_0001, -1, o);
        model_rdata = 32'h7777_0001;
        n_checks++; if (o.addr !== 32'h0000_0048) begin n_fail++; $display("FAIL rmid_next_addr got %h exp 00000048", o.addr); end
        n_checks++; if (o.stalls != 3) begin n_fail++; $display("FAIL rmid_next_stalls got %0d exp 3", o.stalls); end
        n_checks++; if (o.rdata !== model_rdata) begin n_fail++; $display("FAIL rmid_next_rdata got %h exp %h", o.rdata, model_rdata); end
    endtask

`ifdef MEM_BUS_TIMEOUT_EN
    task automatic test_timeout();
        obs_t o;
        run_access(1'b1, 1'b0, 32'h0000_0600, 32'h0, -1, 32'h0, -1, o);
        model_rdata = 32'hDEAD_BEEF;
        n_checks++; if (o.reqs != TB_TIMEOUT) begin n_fail++; $display("FAIL tmo_req_cycles got %0d exp %0d", o.reqs, TB_TIMEOUT); end
        n_checks++; if (o.stalls != TB_TIMEOUT + 1) begin n_fail++; $display("FAIL tmo_stalls got %0d exp %0d", o.stalls, TB_TIMEOUT + 1); end
        n_checks++; if (o.timeout !== 1'b1) begin n_fail++; $display("FAIL tmo_pulse got %b exp 1", o.timeout); end
        n_checks++; if (o.rdata !== model_rdata) begin n_fail++; $display("FAIL tmo_mem_rdata got %h exp %h", o.rdata, model_rdata); end
        @(negedge clk); #1;
        n_checks++; if (bus_timeout !== 1'b0) begin n_fail++; $display("FAIL tmo_pulse_width got %b exp 0", bus_timeout); end
    endtask
`endif

    initial begin
        reset = 1'b1;
        mem_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_flush = 1'b0;
        mem_addr = 32'h0; mem_wdata = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
        repeat (2) @(negedge clk);
        test_reset();
        reset = 1'b0;
        test_passthrough();
        test_load_store();
        test_flush();
        test_back_to_back();
        test_reset_mid();
`ifdef MEM_BUS_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
